// File: rtl/ks_data_path_p.sv
`default_nettype none
// ============================================================================
//  Module   : ks_data_path_p
//  Purpose  : Parametrised K&S data path. It holds the program counter,
//             the 16-bit instruction register and a NUM_REGS-entry register
//             file. It also contains a combinational ALU, a multi-cycle
//             unsigned shift-add multiplier and a registered flag set.
//             Instruction decoding is done in the control unit, which
//             receives the raw opcode field.
//  Ports    : clk, rst               - clock, synchronous active-high reset
//             branch, pc_enable      - PC load select / PC update enable
//             ir_enable              - IR load from data_in[15:0]
//             addr_sel               - 1: ram_addr = PC, 0: IR address field
//             c_sel                  - 1: write-back ALU, 0: write-back data_in
//             operation[2:0]         - ALU operation select
//             op_start               - start multiply (operation = 100)
//             write_reg_enable       - register-file write of R[c_addr]
//             flags_reg_enable       - flag-register load
//             opcode[3:0]            - IR[15:12]
//             op_busy, op_done       - multiplier running / product valid pulse
//             zero_op, neg_op,
//             unsigned_overflow,
//             signed_overflow        - registered flags
//             ram_addr               - memory address
//             data_out               - store data, R[c_addr]
//             data_in                - memory read data
//  Revision : 1.0 - initial release
// ============================================================================
module ks_data_path_p #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic              pc_enable,
  input  logic              ir_enable,
  input  logic              addr_sel,
  input  logic              c_sel,
  input  logic [2:0]        operation,
  input  logic              op_start,
  input  logic              write_reg_enable,
  input  logic              flags_reg_enable,
  output logic [3:0]        opcode,
  output logic              op_busy,
  output logic              op_done,
  output logic              zero_op,
  output logic              neg_op,
  output logic              unsigned_overflow,
  output logic              signed_overflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in
);

  localparam int RA  = $clog2(NUM_REGS);
  localparam int CW  = $clog2(DATA_W) + 1;
  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_AND  = 3'b010;
  localparam logic [2:0] c_OP_OR   = 3'b011;
  localparam logic [2:0] c_OP_MUL  = 3'b100;
  localparam logic [2:0] c_OP_SHL  = 3'b101;
  localparam logic [2:0] c_OP_SHR  = 3'b110;

  // Architectural state
  logic [ADDR_W-1:0]   r_pc;
  logic [15:0]         r_ir;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_zero;
  logic                r_neg;
  logic                r_uov;
  logic                r_sov;

  // Multiplier state
  logic [2*DATA_W-1:0] r_prod;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;

  // Decoded fields and datapath wires
  logic [RA-1:0]       w_c_addr;
  logic [RA-1:0]       w_a_addr;
  logic [RA-1:0]       w_b_addr;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_res;
  logic                w_uov;
  logic                w_sov;
  logic [DATA_W-1:0]   w_bus_c;
  logic                w_mul_sel;
  logic                w_accept;
  logic                w_blocked;

  assign w_c_addr = r_ir[8 +: RA];
  assign w_a_addr = r_ir[4 +: RA];
  assign w_b_addr = r_ir[0 +: RA];

  assign w_a      = r_regs[w_a_addr];
  assign w_b      = r_regs[w_b_addr];
  assign data_out = r_regs[w_c_addr];

  assign opcode   = r_ir[15:12];
  assign ram_addr = addr_sel ? r_pc : r_ir[ADDR_W-1:0];

  // Widened by one bit so the top bit is the carry (add) or borrow (sub).
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_res = w_a;
    w_uov = 1'b0;
    w_sov = 1'b0;
    case (operation)
      c_OP_ADD: begin
        w_res = w_sum[DATA_W-1:0];
        w_uov = w_sum[DATA_W];
        w_sov = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
      end
      c_OP_SUB: begin
        w_res = w_diff[DATA_W-1:0];
        w_uov = w_diff[DATA_W];
        w_sov = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
      end
      c_OP_AND: w_res = w_a & w_b;
      c_OP_OR:  w_res = w_a | w_b;
      c_OP_MUL: begin
        w_res = r_prod[DATA_W-1:0];
        w_uov = |r_prod[2*DATA_W-1:DATA_W];
      end
      c_OP_SHL: {w_uov, w_res} = {w_a, 1'b0};
      c_OP_SHR: {w_res, w_uov} = {1'b0, w_a};
      default:  w_res = w_a;
    endcase
  end

  assign w_bus_c   = c_sel ? w_res : data_in;
  assign w_mul_sel = (operation == c_OP_MUL);
  assign w_accept  = op_start && w_mul_sel && !r_busy;
  // A multiply-result write while the product is still forming is dropped.
  assign w_blocked = w_mul_sel && r_busy;

  // PC, IR, register file and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_uov  <= 1'b0;
      r_sov  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (pc_enable) begin
        r_pc <= branch ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(1);
      end
      if (ir_enable) begin
        r_ir <= data_in[15:0];
      end
      if (write_reg_enable && !w_blocked) begin
        r_regs[w_c_addr] <= w_bus_c;
      end
      if (flags_reg_enable && !w_blocked) begin
        r_zero <= (w_res == '0);
        r_neg  <= w_res[MSB];
        r_uov  <= w_uov;
        r_sov  <= w_sov;
      end
    end
  end

  // Shift-add multiplier: one partial product per busy cycle. The
  // multiplicand moves left and the multiplier moves right, so bit 0 of
  // r_mplier always gates the current partial product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand  <= {{DATA_W{1'b0}}, w_a};
        r_mplier <= w_b;
        r_prod   <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) begin
          r_prod <= r_prod + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (r_cnt == CW'(DATA_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign op_busy           = r_busy;
  assign op_done           = r_done;
  assign zero_op           = r_zero;
  assign neg_op            = r_neg;
  assign unsigned_overflow = r_uov;
  assign signed_overflow   = r_sov;

endmodule
`default_nettype wire

// File: tb/tb_ks_data_path_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ks_data_path_p
//  Purpose  : Self-checking bench for ks_data_path_p (default parameters).
//             Directed ALU vectors come from a table. Hand-written sequences
//             cover the PC, the multiplier and reset. A random phase is
//             compared every cycle against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ks_data_path_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic        pc_enable;
  logic        ir_enable;
  logic        addr_sel;
  logic        c_sel;
  logic [2:0]  operation;
  logic        op_start;
  logic        write_reg_enable;
  logic        flags_reg_enable;
  logic [3:0]  opcode;
  logic        op_busy;
  logic        op_done;
  logic        zero_op;
  logic        neg_op;
  logic        unsigned_overflow;
  logic        signed_overflow;
  logic [4:0]  ram_addr;
  logic [15:0] data_out;
  logic [15:0] data_in;

  ks_data_path_p #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .branch            (branch),
    .pc_enable         (pc_enable),
    .ir_enable         (ir_enable),
    .addr_sel          (addr_sel),
    .c_sel             (c_sel),
    .operation         (operation),
    .op_start          (op_start),
    .write_reg_enable  (write_reg_enable),
    .flags_reg_enable  (flags_reg_enable),
    .opcode            (opcode),
    .op_busy           (op_busy),
    .op_done           (op_done),
    .zero_op           (zero_op),
    .neg_op            (neg_op),
    .unsigned_overflow (unsigned_overflow),
    .signed_overflow   (signed_overflow),
    .ram_addr          (ram_addr),
    .data_out          (data_out),
    .data_in           (data_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- reference model state ----------------
  int unsigned       m_regs [4];
  logic [15:0]       m_ir;
  int unsigned       m_pc;
  bit                m_z, m_n, m_u, m_s;
  longint unsigned   m_prod;
  longint unsigned   m_pending;
  bit                m_active;
  int                m_start;
  int                m_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, m_cyc);
    end
  endtask

  // ALU behaviour from arithmetic: overflow is detected by range, not bits.
  function automatic void ref_alu(input logic [2:0] op, input int unsigned a,
                                  input int unsigned b, input longint unsigned prod,
                                  output int unsigned res, output bit u, output bit s);
    int sa, sb, t;
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    u = 0;
    s = 0;
    res = a;
    case (op)
      3'd0: begin res = (a + b) % 65536; u = (a + b) > 65535; t = sa + sb; s = (t > 32767) || (t < -32768); end
      3'd1: begin res = (a + 65536 - b) % 65536; u = (a < b); t = sa - sb; s = (t > 32767) || (t < -32768); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: begin res = int'(prod % 65536); u = (prod > 65535); end
      3'd5: begin res = (a * 2) % 65536; u = (a >= 32768); end
      3'd6: begin res = a / 2; u = (a % 2) == 1; end
      default: res = a;
    endcase
  endfunction

  function automatic bit m_busy();
    int off;
    off = m_cyc - m_start;
    return m_active && (off >= 1) && (off <= 16);
  endfunction

  function automatic bit m_done();
    return m_active && ((m_cyc - m_start) == 17);
  endfunction

  task automatic model_edge();
    int unsigned a, b, res;
    bit u, s, busy_now, blocked;
    int ci;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_ir = '0; m_pc = 0;
      m_z = 0; m_n = 0; m_u = 0; m_s = 0;
      m_prod = 0; m_active = 0;
    end else begin
      a  = m_regs[m_ir[5:4]];
      b  = m_regs[m_ir[1:0]];
      ci = int'(m_ir[9:8]);
      busy_now = m_busy();
      blocked  = (operation == 3'd4) && busy_now;
      ref_alu(operation, a, b, m_prod, res, u, s);
      if (write_reg_enable && !blocked)
        m_regs[ci] = c_sel ? res : int'(data_in);
      if (flags_reg_enable && !blocked) begin
        m_z = (res == 0); m_n = (res >= 32768); m_u = u; m_s = s;
      end
      if (op_start && operation == 3'd4 && !busy_now) begin
        m_active  = 1;
        m_start   = m_cyc;
        m_pending = longint'(a) * longint'(b);
      end
      if (pc_enable) m_pc = branch ? int'(m_ir[4:0]) : (m_pc + 1) % 32;
      if (ir_enable) m_ir = data_in;
    end
    m_cyc++;
    if (m_active && (m_cyc - m_start) == 17) m_prod = m_pending;
  endtask

  task automatic check_outputs();
    chk("ram_addr", 32'(ram_addr), addr_sel ? m_pc : 32'(m_ir[4:0]));
    chk("opcode",   32'(opcode),   32'(m_ir[15:12]));
    chk("data_out", 32'(data_out), m_regs[m_ir[9:8]]);
    chk("zero",     32'(zero_op),  32'(m_z));
    chk("neg",      32'(neg_op),   32'(m_n));
    chk("uovf",     32'(unsigned_overflow), 32'(m_u));
    chk("sovf",     32'(signed_overflow),   32'(m_s));
    chk("op_busy",  32'(op_busy),  32'(m_busy()));
    chk("op_done",  32'(op_done),  32'(m_done()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    operation = 3'd0; op_start = 0; write_reg_enable = 0; flags_reg_enable = 0;
  endtask

  task automatic set_ir(input logic [15:0] v);
    idle();
    data_in = v; ir_enable = 1;
    tick();
    ir_enable = 0;
  endtask

  task automatic write_reg(input int idx, input logic [15:0] v);
    set_ir(16'(idx << 8));
    data_in = v; c_sel = 0; write_reg_enable = 1;
    tick();
    write_reg_enable = 0;
  endtask

  // Multiply R2*R3 with IR = 0x0123; checks latency and the result written to R1.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit restart,
                         input logic [15:0] exp_res, input bit ez, input bit en, input bit eu);
    int busy_n, done_at;
    write_reg(2, a);
    write_reg(3, b);
    set_ir(16'h0123);
    operation = 3'd4; op_start = 1;
    tick();
    op_start = 0;
    busy_n = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (op_done) begin done_at = k; break; end
      if (op_busy) busy_n++;
      op_start = restart && (k == 4);
      tick();
    end
    op_start = 0;
    chk("mul_busy_cycles", 32'(busy_n), 32'd16);
    chk("mul_done_cycle", 32'(done_at), 32'd17);
    c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1; operation = 3'd4;
    tick();
    idle();
    chk("mul_res",  32'(data_out), 32'(exp_res));
    chk("mul_zero", 32'(zero_op), 32'(ez));
    chk("mul_neg",  32'(neg_op), 32'(en));
    chk("mul_uovf", 32'(unsigned_overflow), 32'(eu));
    chk("mul_sovf", 32'(signed_overflow), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z, n, u, s;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cnt;
    tbl[0] = '{3'd0, 16'd5,     16'd7,     16'd12,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3'd0, 16'h7FFF,  16'h0001,  16'h8000,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{3'd1, 16'd3,     16'd5,     16'hFFFE,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{3'd2, 16'hF0F0,  16'h0FF0,  16'h00F0,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{3'd3, 16'hF000,  16'h000F,  16'hF00F,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 16'h8001,  16'h1111,  16'h0002,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{3'd6, 16'h0003,  16'h2222,  16'h0001,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{3'd7, 16'h0000,  16'h1234,  16'h0000,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{3'd1, 16'h8000,  16'h0001,  16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{3'd0, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_ir = '0; m_pc = 0; m_z = 0; m_n = 0; m_u = 0; m_s = 0;
    m_prod = 0; m_pending = 0; m_active = 0; m_start = 0; m_cyc = 0;

    idle();
    data_in = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_opcode",   32'(opcode),   32'd0);
    chk("rst_busy",     32'(op_busy),  32'd0);

    // PC counts with wrap at 32
    addr_sel = 1; pc_enable = 1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("pc_seq", 32'(ram_addr), 32'((i + 1) % 32));
    end
    idle();

    // Directed ALU vectors: R1 = R2 op R3
    for (int i = 0; i < 10; i++) begin
      write_reg(2, tbl[i].a);
      write_reg(3, tbl[i].b);
      set_ir(16'h0123);
      operation = tbl[i].op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1;
      tick();
      idle();
      chk("alu_res",  32'(data_out), 32'(tbl[i].res));
      chk("alu_zero", 32'(zero_op), 32'(tbl[i].z));
      chk("alu_neg",  32'(neg_op), 32'(tbl[i].n));
      chk("alu_uovf", 32'(unsigned_overflow), 32'(tbl[i].u));
      chk("alu_sovf", 32'(signed_overflow), 32'(tbl[i].s));
    end

    // Multiplier: overflowing product, normal product, ignored restart
    run_mul(16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_mul(16'd300,  16'd200,  1'b0, 16'd60000, 1'b0, 1'b1, 1'b0);
    run_mul(16'd300,  16'd200,  1'b1, 16'd60000, 1'b0, 1'b1, 1'b0);

    // Reset in cycle 5 of a multiply: busy drops, no done pulse follows
    write_reg(2, 16'd9);
    write_reg(3, 16'd11);
    set_ir(16'h0123);
    operation = 3'd4; op_start = 1;
    tick();
    op_start = 0;
    for (int k = 1; k < 5; k++) tick();
    rst = 1;
    tick();
    chk("rst_mid_busy", 32'(op_busy), 32'd0);
    rst = 0;
    idle();
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (op_done) cnt++;
    end
    chk("rst_mid_no_done", 32'(cnt), 32'd0);

    // Branch, IR address field, store data
    set_ir(16'h001A);
    pc_enable = 1; branch = 1; addr_sel = 1;
    tick();
    idle();
    addr_sel = 1;
    #1;
    chk("branch_pc", 32'(ram_addr), 32'h1A);
    write_reg(2, 16'hBEEF);
    chk("store_data", 32'(data_out), 32'hBEEF);
    set_ir(16'h0215);
    chk("ir_addr", 32'(ram_addr), 32'h15);

    // Random phase against the reference model
    for (int i = 0; i < 800; i++) begin
      rst              = ($urandom_range(0, 149) == 0);
      branch           = 1'($urandom);
      pc_enable        = 1'($urandom);
      ir_enable        = ($urandom_range(0, 3) == 0);
      addr_sel         = 1'($urandom);
      c_sel            = 1'($urandom);
      operation        = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom);
      op_start         = ($urandom_range(0, 3) == 0);
      write_reg_enable = 1'($urandom);
      flags_reg_enable = 1'($urandom);
      data_in          = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
